// File: rtl/contador_lote_garrafas_pkg.sv
// Shared constants for the bottle/dozen lot counter: default geometry, counting
// modes and an elaboration-time legality check for the parameter set.
package contador_lote_garrafas_pkg;

  localparam int DEF_BOTTLE_W          = 4;
  localparam int DEF_DOZEN_W           = 4;
  localparam int DEF_BOTTLES_PER_DOZEN = 12;
  localparam int DEF_MAX_DOZENS        = 10;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // True when the bottle modulus and terminal dozen value fit their widths.
  function automatic bit params_ok(input int bottle_w, input int dozen_w,
                                   input int bottles_per_dozen, input int max_dozens,
                                   input int saturate);
    bit ok;
    ok = 1'b1;
    if (bottle_w < 1 || bottle_w > 30) ok = 1'b0;
    if (dozen_w < 1 || dozen_w > 30) ok = 1'b0;
    if (ok) begin
      if (bottles_per_dozen < 2 || bottles_per_dozen > (1 << bottle_w)) ok = 1'b0;
      if (max_dozens < 1 || max_dozens > ((1 << dozen_w) - 1)) ok = 1'b0;
    end
    if (saturate != MODE_WRAP && saturate != MODE_SAT) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/contador_lote_garrafas_modulo.sv
// Generic modulo/terminal counter: counts 0..TERMINAL, then wraps (pulsing WRAP)
// or holds at TERMINAL when SAT_MODE is set.
module contador_modulo #(
  parameter int W = 4
) (
  input  logic         CLOCK,
  input  logic         RESET,
  input  logic         CLEAR,
  input  logic         ENABLE,
  input  logic [W-1:0] TERMINAL,
  input  logic         SAT_MODE,
  output logic [W-1:0] COUNT,
  output logic         TC,
  output logic         WRAP
);

  logic [W-1:0] count_q, count_d;
  logic         wrap_q, wrap_d;

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (CLEAR) begin
      count_d = '0;
    end else if (ENABLE) begin
      // Terminal compare rather than binary rollover keeps any modulus exact.
      if (count_q == TERMINAL) begin
        if (!SAT_MODE) begin
          count_d = '0;
          wrap_d  = 1'b1;
        end
      end else begin
        count_d = count_q + W'(1);
      end
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign COUNT = count_q;
  assign TC    = (count_q == TERMINAL);
  assign WRAP  = wrap_q;

endmodule

// File: rtl/contador_lote_garrafas.sv
// Two-stage bottle/dozen lot counter feeding the lot/box controller with a
// registered dozen tick, a FULL decode and a sticky overflow flag.
module contador_lote_garrafas
  import contador_lote_garrafas_pkg::*;
#(
  parameter int BOTTLE_W          = DEF_BOTTLE_W,
  parameter int DOZEN_W           = DEF_DOZEN_W,
  parameter int BOTTLES_PER_DOZEN = DEF_BOTTLES_PER_DOZEN,
  parameter int MAX_DOZENS        = DEF_MAX_DOZENS,
  parameter int SATURATE          = MODE_WRAP
) (
  input  logic                CLOCK,
  input  logic                RESET,
  input  logic                CLEAR,
  input  logic                ENABLE,
  output logic [BOTTLE_W-1:0] BOTTLES,
  output logic [DOZEN_W-1:0]  COUNT,
  output logic                DOZEN_TICK,
  output logic                FULL,
  output logic                OVERFLOW
);

  if (!params_ok(BOTTLE_W, DOZEN_W, BOTTLES_PER_DOZEN, MAX_DOZENS, SATURATE)) begin : g_bad_params
    $error("contador_lote_garrafas: illegal parameter combination");
  end

  localparam logic [BOTTLE_W-1:0] BOTTLE_TERM = BOTTLE_W'(BOTTLES_PER_DOZEN - 1);
  localparam logic [DOZEN_W-1:0]  DOZEN_TERM  = DOZEN_W'(MAX_DOZENS);
  localparam logic                SAT_MODE    = (SATURATE == MODE_SAT);

  logic [BOTTLE_W-1:0] bottle_count;
  logic [DOZEN_W-1:0]  dozen_count;
  logic                bottle_tc, bottle_wrap;
  logic                dozen_tc, dozen_wrap;
  logic                full;
  logic                bottle_en, dozen_en, ovf_evt;
  logic                tick_q, tick_d;
  logic                ovf_q, ovf_d;

  assign full = (dozen_count == DOZEN_TERM);

  // A saturated, full lot freezes the bottle stage so nothing more is counted.
  assign bottle_en = ENABLE && !(SAT_MODE && full);
  assign dozen_en  = bottle_en && bottle_tc;
  assign ovf_evt   = ENABLE && full && (SAT_MODE || bottle_tc);

  contador_modulo #(
    .W (BOTTLE_W)
  ) u_bottle_stage (
    .CLOCK    (CLOCK),
    .RESET    (RESET),
    .CLEAR    (CLEAR),
    .ENABLE   (bottle_en),
    .TERMINAL (BOTTLE_TERM),
    .SAT_MODE (1'b0),
    .COUNT    (bottle_count),
    .TC       (bottle_tc),
    .WRAP     (bottle_wrap)
  );

  contador_modulo #(
    .W (DOZEN_W)
  ) u_dozen_stage (
    .CLOCK    (CLOCK),
    .RESET    (RESET),
    .CLEAR    (CLEAR),
    .ENABLE   (dozen_en),
    .TERMINAL (DOZEN_TERM),
    .SAT_MODE (SAT_MODE),
    .COUNT    (dozen_count),
    .TC       (dozen_tc),
    .WRAP     (dozen_wrap)
  );

  always_comb begin
    tick_d = 1'b0;
    ovf_d  = ovf_q;
    if (CLEAR) begin
      ovf_d = 1'b0;
    end else begin
      tick_d = dozen_en;
      if (ovf_evt) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      tick_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      tick_q <= tick_d;
      ovf_q  <= ovf_d;
    end
  end

  // The bottle stage's own wrap pulse must coincide with the dozen tick, and a
  // dozen-stage wrap is always an overflow.
  a_tick_matches_wrap: assert property (@(posedge CLOCK) bottle_wrap == tick_q);
  a_wrap_sets_ovf:     assert property (@(posedge CLOCK) dozen_wrap |-> ovf_q);
  a_full_matches_tc:   assert property (@(posedge CLOCK) dozen_tc == full);

  assign BOTTLES    = bottle_count;
  assign COUNT      = dozen_count;
  assign DOZEN_TICK = tick_q;
  assign FULL       = full;
  assign OVERFLOW   = ovf_q;

endmodule
